// File: rtl/irq_pkg.sv
// Shared types and constants for the irq_ctrl_n interrupt controller.
package irq_pkg;

    typedef enum logic {
        StIdle,
        StAck
    } state_e;

    localparam logic [1:0] AddrImr  = 2'd0;
    localparam logic [1:0] AddrMode = 2'd1;
    localparam logic [1:0] AddrEoi  = 2'd2;
    localparam logic [1:0] AddrStat = 2'd3;

    // Wide enough for any legal vector width; sliced to VEC_W at the point of use.
    localparam logic [31:0] SpuriousVecAll = 32'hFFFF_FFFF;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; idx is zero when nothing is set.
module irq_prio_enc #(
    parameter int unsigned W     = 8,
    parameter int unsigned IDX_W = 4
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl_n.sv
// Parametrised priority interrupt controller with edge/level lines, mask,
// nested in-service tracking and a vectored acknowledge handshake.
module irq_ctrl_n
    import irq_pkg::*;
#(
    parameter int unsigned      NUM_IRQ  = 8,
    parameter int unsigned      VEC_W    = 8,
    parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'('h20),
    parameter bit               AUTO_EOI = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] ir,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [NUM_IRQ-1:0] cfg_wdata,
    output logic [NUM_IRQ-1:0] cfg_rdata,
    output logic               intr_o,
    input  logic               inta_i,
    output logic [VEC_W-1:0]   vector_o,
    output logic               vector_valid
);

    localparam int unsigned IdxW = $clog2(NUM_IRQ + 1);

    state_e state_q, state_d;

    logic [NUM_IRQ-1:0] imr_q, imr_d, mode_q, mode_d, irr_q, irr_d, isr_q, isr_d;
    logic [NUM_IRQ-1:0] ir_q, rdata_q, rdata_d, ack_mask;
    logic               inta_q, intr_q, intr_d, lat_valid_q, lat_valid_d;
    logic [IdxW-1:0]    lat_idx_q, lat_idx_d, hp_idx, hs_raw, hs_idx;
    logic [VEC_W-1:0]   vector_q, vector_d;
    logic               hp_found, hs_found, eligible, inta_rise;

    irq_prio_enc #(.W(NUM_IRQ), .IDX_W(IdxW)) u_hp_enc (
        .vec   (irr_q & ~imr_q),
        .idx   (hp_idx),
        .found (hp_found)
    );

    irq_prio_enc #(.W(NUM_IRQ), .IDX_W(IdxW)) u_hs_enc (
        .vec   (isr_q),
        .idx   (hs_raw),
        .found (hs_found)
    );

    assign hs_idx    = hs_found ? hs_raw : IdxW'(NUM_IRQ);
    assign eligible  = hp_found && (hp_idx < hs_idx);
    assign inta_rise = inta_i & ~inta_q;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (inta_rise) state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        intr_o       = intr_q && (state_q == StIdle);
        vector_valid = (state_q == StAck);
        vector_o     = vector_q;
        cfg_rdata    = rdata_q;
    end

    always_comb begin
        lat_valid_d = lat_valid_q;
        lat_idx_d   = lat_idx_q;
        vector_d    = vector_q;
        if (state_q == StIdle && inta_rise) begin
            lat_valid_d = eligible;
            lat_idx_d   = hp_idx;
            vector_d    = eligible ? VEC_BASE + VEC_W'(hp_idx) : SpuriousVecAll[VEC_W-1:0];
        end

        ack_mask = '0;
        if (state_q == StAck && lat_valid_q) begin
            ack_mask = NUM_IRQ'(1) << lat_idx_q;
        end

        // A fresh edge on the line being acknowledged keeps its request alive.
        irr_d = (mode_q & ((irr_q & ~ack_mask) | (ir & ~ir_q))) | (~mode_q & ir);

        isr_d = isr_q;
        if (cfg_we && cfg_addr == AddrEoi) isr_d = isr_d & ~cfg_wdata;
        if (!AUTO_EOI) isr_d = isr_d | ack_mask;

        imr_d  = (cfg_we && cfg_addr == AddrImr) ? cfg_wdata : imr_q;
        mode_d = (cfg_we && cfg_addr == AddrMode) ? cfg_wdata : mode_q;

        unique case (cfg_addr)
            AddrImr:  rdata_d = imr_q;
            AddrMode: rdata_d = mode_q;
            AddrEoi:  rdata_d = isr_q;
            AddrStat: rdata_d = irr_q;
            default:  rdata_d = '0;
        endcase

        // Held low through the cycle after ACK so the just-serviced line cannot re-request.
        intr_d = eligible && (state_q == StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imr_q       <= '1;
            mode_q      <= '0;
            irr_q       <= '0;
            isr_q       <= '0;
            ir_q        <= '0;
            inta_q      <= 1'b0;
            intr_q      <= 1'b0;
            lat_valid_q <= 1'b0;
            lat_idx_q   <= '0;
            vector_q    <= '0;
            rdata_q     <= '0;
        end else begin
            imr_q       <= imr_d;
            mode_q      <= mode_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            ir_q        <= ir;
            inta_q      <= inta_i;
            intr_q      <= intr_d;
            lat_valid_q <= lat_valid_d;
            lat_idx_q   <= lat_idx_d;
            vector_q    <= vector_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Bench for irq_ctrl_n: two instances (explicit and automatic EOI) checked every
// cycle against a behavioural model, plus directed scenarios with literal expectations.
module tb_irq_ctrl_n;

    logic       clk = 1'b0;
    logic       reset, cfg_we, inta;
    logic [7:0] ir, cfg_wdata;
    logic [1:0] cfg_addr;

    logic       intr0, intr1, vv0, vv1;
    logic [7:0] vec0, vec1, rd0, rd1;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    irq_ctrl_n #(.AUTO_EOI(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .ir(ir), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(rd0), .intr_o(intr0), .inta_i(inta),
        .vector_o(vec0), .vector_valid(vv0)
    );

    irq_ctrl_n #(.AUTO_EOI(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .ir(ir), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(rd1), .intr_o(intr1), .inta_i(inta),
        .vector_o(vec1), .vector_valid(vv1)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model, one copy per instance (index 1 has automatic EOI).
    logic [7:0] m_imr[2], m_mode[2], m_irr[2], m_isr[2], m_irp[2], m_vec[2], m_rd[2];
    bit         m_ack[2], m_intr[2];
    int         m_lat[2];
    bit         m_inta_prev;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_imr[k] = 8'hFF; m_mode[k] = 8'h00; m_irr[k] = 8'h00; m_isr[k] = 8'h00;
                m_irp[k] = 8'h00; m_vec[k] = 8'h00; m_rd[k] = 8'h00;
                m_ack[k] = 1'b0; m_intr[k] = 1'b0; m_lat[k] = -1;
            end else begin
                int  hp, hs, set_bit;
                bit  elig, new_ack, rise;
                logic [7:0] n_irr, n_isr;
                hp = -1;
                hs = 8;
                for (int i = 0; i < 8; i++) begin
                    if (hp < 0 && m_irr[k][i] && !m_imr[k][i]) hp = i;
                    if (hs == 8 && m_isr[k][i]) hs = i;
                end
                elig = (hp >= 0) && (hp < hs);
                case (cfg_addr)
                    2'd0: m_rd[k] = m_imr[k];
                    2'd1: m_rd[k] = m_mode[k];
                    2'd2: m_rd[k] = m_isr[k];
                    default: m_rd[k] = m_irr[k];
                endcase
                set_bit = (m_ack[k] && m_lat[k] >= 0) ? m_lat[k] : -1;
                new_ack = !m_ack[k] && inta && !m_inta_prev;
                n_irr = m_irr[k];
                for (int i = 0; i < 8; i++) begin
                    rise = ir[i] && !m_irp[k][i];
                    if (m_mode[k][i]) begin
                        if (i == set_bit) n_irr[i] = 1'b0;
                        if (rise) n_irr[i] = 1'b1;
                    end else begin
                        n_irr[i] = ir[i];
                    end
                end
                n_isr = m_isr[k];
                if (cfg_we && cfg_addr == 2'd2) n_isr = n_isr & ~cfg_wdata;
                if (k == 0 && set_bit >= 0) n_isr[set_bit] = 1'b1;
                if (cfg_we && cfg_addr == 2'd0) m_imr[k] = cfg_wdata;
                if (cfg_we && cfg_addr == 2'd1) m_mode[k] = cfg_wdata;
                m_irr[k]  = n_irr;
                m_isr[k]  = n_isr;
                m_intr[k] = !m_ack[k] && !new_ack && elig;
                if (new_ack) begin
                    m_lat[k] = elig ? hp : -1;
                    m_vec[k] = elig ? 8'h20 + 8'(hp) : 8'hFF;
                end
                m_ack[k] = new_ack;
                m_irp[k] = ir;
            end
        end
        m_inta_prev = reset ? 1'b0 : inta;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m0.intr_o", {7'd0, intr0}, {7'd0, m_intr[0]});
            chk("m0.vector_valid", {7'd0, vv0}, {7'd0, m_ack[0]});
            chk("m0.vector_o", vec0, m_vec[0]);
            chk("m0.cfg_rdata", rd0, m_rd[0]);
            chk("m1.intr_o", {7'd0, intr1}, {7'd0, m_intr[1]});
            chk("m1.vector_valid", {7'd0, vv1}, {7'd0, m_ack[1]});
            chk("m1.vector_o", vec1, m_vec[1]);
            chk("m1.cfg_rdata", rd1, m_rd[1]);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        reset = 1'b1; cfg_we = 1'b0; inta = 1'b0; ir = 8'h00; cfg_wdata = 8'h00; cfg_addr = 2'd0;
        step(2);
        cmp_en = 1'b1;
        reset = 1'b0;
        chk("reset intr_o", {7'd0, intr0}, 8'h00);
        chk("reset vector_valid", {7'd0, vv0}, 8'h00);
        chk("reset vector_o", vec0, 8'h00);
        step();
        chk("reset IMR read", rd0, 8'hFF);

        // 1: edge line 3
        wr(2'd0, 8'h00);
        wr(2'd1, 8'hFF);
        ir = 8'h08; step(); ir = 8'h00;
        chk("t1 intr at +1", {7'd0, intr0}, 8'h00);
        step();
        chk("t1 intr at +2", {7'd0, intr0}, 8'h01);
        inta = 1'b1; step();
        chk("t1 vector", vec0, 8'h23);
        chk("t1 valid", {7'd0, vv0}, 8'h01);
        chk("t1 intr in ack", {7'd0, intr0}, 8'h00);
        step();
        chk("t1 valid drops", {7'd0, vv0}, 8'h00);
        cfg_addr = 2'd2; step();
        chk("t1 ISR", rd0, 8'h08);
        cfg_addr = 2'd3; step();
        chk("t1 IRR", rd0, 8'h00);
        inta = 1'b0;

        // 2: nesting
        ir = 8'h20; step(); ir = 8'h00; step(2);
        chk("t2 lower waits", {7'd0, intr0}, 8'h00);
        ir = 8'h02; step(); ir = 8'h00; step();
        chk("t2 higher nests", {7'd0, intr0}, 8'h01);
        inta = 1'b1; step();
        chk("t2 vector 21", vec0, 8'h21);
        step(); inta = 1'b0;
        cfg_addr = 2'd2; step();
        chk("t2 ISR", rd0, 8'h0A);
        wr(2'd2, 8'h02);
        wr(2'd2, 8'h08);
        step();
        chk("t2 line5 request", {7'd0, intr0}, 8'h01);
        inta = 1'b1; step();
        chk("t2 vector 25", vec0, 8'h25);
        step(); inta = 1'b0;
        wr(2'd2, 8'h20);

        // 3: level line 0
        wr(2'd1, 8'hFE);
        ir = 8'h01; step(3);
        chk("t3 level request", {7'd0, intr0}, 8'h01);
        inta = 1'b1; step();
        chk("t3 vector 20", vec0, 8'h20);
        step(); inta = 1'b0; step();
        chk("t3 in service", {7'd0, intr0}, 8'h00);
        wr(2'd2, 8'h01);
        step();
        chk("t3 reassert", {7'd0, intr0}, 8'h01);
        ir = 8'h00; step(2);
        chk("t3 released", {7'd0, intr0}, 8'h00);
        cfg_addr = 2'd3; step();
        chk("t3 IRR", rd0, 8'h00);

        // 4: masking
        wr(2'd0, 8'hFF);
        ir = 8'h04; step(); ir = 8'h00; step(2);
        cfg_addr = 2'd3; step();
        chk("t4 IRR masked", rd0, 8'h04);
        chk("t4 intr masked", {7'd0, intr0}, 8'h00);
        wr(2'd0, 8'h00);
        step();
        chk("t4 unmask", {7'd0, intr0}, 8'h01);
        inta = 1'b1; step();
        chk("t4 vector 22", vec0, 8'h22);
        step(); inta = 1'b0;
        wr(2'd2, 8'h04);

        // 5: spurious, held acknowledge
        step();
        inta = 1'b1; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) chk("t5 spurious vector", vec0, 8'hFF);
            cnt += vv0;
        end
        chk("t5 single strobe", 8'(cnt), 8'h01);
        inta = 1'b0;
        cfg_addr = 2'd2; step();
        chk("t5 ISR unchanged", rd0, 8'h00);

        // 6: automatic EOI, reset during ACK
        do_reset();
        wr(2'd0, 8'h00);
        wr(2'd1, 8'hFF);
        cfg_addr = 2'd2;
        for (int r = 0; r < 2; r++) begin
            ir = 8'h10; step(); ir = 8'h00; step();
            chk("t6 intr", {7'd0, intr1}, 8'h01);
            inta = 1'b1; step();
            chk("t6 vector 24", vec1, 8'h24);
            chk("t6 valid", {7'd0, vv1}, 8'h01);
            chk("t6 ISR a", rd1, 8'h00);
            inta = 1'b0; step();
            chk("t6 ISR b", rd1, 8'h00);
            step();
            chk("t6 ISR c", rd1, 8'h00);
        end
        inta = 1'b1; step();
        chk("t6 in ack", {7'd0, vv1}, 8'h01);
        reset = 1'b1; step();
        reset = 1'b0; inta = 1'b0;
        chk("t6 rst intr", {7'd0, intr0 | intr1}, 8'h00);
        chk("t6 rst valid", {7'd0, vv0 | vv1}, 8'h00);
        chk("t6 rst vector", vec0 | vec1, 8'h00);
        chk("t6 rst rdata", rd0 | rd1, 8'h00);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            ir        = 8'($urandom) & 8'($urandom);
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_wdata = 8'($urandom);
            if ($urandom_range(0, 3) == 0) inta = ~inta;
            reset     = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0; cfg_we = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_ctrl_n.md
# irq_ctrl_n

Parametrised priority interrupt controller: the successor to the 8-line `pic`. It is generalised to `NUM_IRQ` lines and adds the following:
- per-line edge/level mode;
- a writable mask;
- nested in-service tracking with explicit or automatic end-of-interrupt (EOI);
- a vectored acknowledge handshake toward the CPU/bus side (`intr_o` / `inta_i`).

It sits between peripheral interrupt sources (PWM, bus bridges, switches) and the processor's external interrupt input.

## Interface
- `NUM_IRQ`, 8: number of request lines, 2..32; line 0 has the highest priority.
- `VEC_W`, 8: vector width; must satisfy 2^`VEC_W` > `VEC_BASE`+`NUM_IRQ`.
- `VEC_BASE`, 8'h20: vector of line 0; line i returns `VEC_BASE`+i.
- `AUTO_EOI`, 0: 1 = clear the in-service bit at acknowledge instead of waiting for an EOI write.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `ir`  in  `NUM_IRQ`  request lines, already synchronous to `clk`.
- `cfg_we`  in  1  register write strobe.
- `cfg_addr`  in  2  register select: 0 = IMR, 1 = MODE, 2 = EOI, 3 = read-only status.
- `cfg_wdata`  in  `NUM_IRQ`  write data.
- `cfg_rdata`  out  `NUM_IRQ`  read data, registered: 0 = IMR, 1 = MODE, 2 = ISR, 3 = IRR.
- `intr_o`  out  1  interrupt request to the CPU.
- `inta_i`  in  1  acknowledge level from the CPU.
- `vector_o`  out  `VEC_W`  acknowledged vector.
- `vector_valid`  out  1  one-cycle strobe qualifying `vector_o`.

## Operation
- **Registers:**
  - IMR: mask, 1 = masked.
  - MODE: 1 = edge, 0 = level.
  - IRR: request register.
  - ISR: in-service register.
  - `ir_q`: previous `ir`.
- **Reset:** IMR = all 1s; MODE = 0; IRR = ISR = `ir_q` = 0; `intr_o` = 0; `vector_o` = 0; `vector_valid` = 0; `cfg_rdata` = 0; FSM goes to IDLE.
- **Edge line:** IRR[i] is set when `ir`[i] & ~`ir_q`[i]. It is cleared only when line i is acknowledged.
- **Level line:** IRR[i] = `ir`[i] every cycle; the acknowledge does not clear it.
- **Masking:** masking does not clear IRR. Pending = IRR & ~IMR.
- **Priority:**
  - `hp` = lowest-index pending bit.
  - `hs` = lowest-index ISR bit, or `NUM_IRQ` if ISR = 0.
  - `eligible` = pending bit exists with `hp` < `hs`. Only strictly higher priority nests; equal or lower priority waits.
- **`intr_o`:** registered `eligible` while in IDLE. It is forced to 0 in the ACK state.
- **FSM:**
  - IDLE: waits for a rising edge of `inta_i` (`inta_i` & ~`inta_q`). On the edge, latches `hp` (or "none"), then goes to ACK.
  - ACK, one cycle:
    - drives `vector_o`, asserts `vector_valid`;
    - if a line was latched: sets ISR[`hp`] (skipped when `AUTO_EOI` = 1) and clears IRR[`hp`] if that line is edge mode;
    - returns to IDLE.
- **Spurious acknowledge** (nothing eligible at the `inta_i` edge): `vector_o` = all 1s; `vector_valid` = 1; ISR/IRR unchanged.
- **EOI write** (`cfg_addr` = 2): ISR &= ~`cfg_wdata`.
- **Simultaneous events:**
  - EOI and ACK set in the same cycle: the set wins for the acked bit.
  - New edge on a line being cleared by ACK: IRR stays 1.
  - IMR write during ACK: the latched vector is unaffected.
- **Writes and reads:**
  - Writes to address 3 are ignored.
  - `cfg_rdata` reflects register state as of the cycle before the read-address sample.

## Timing
- `ir` edge at cycle t → IRR at t+1 → `intr_o` at t+2, if unmasked and eligible.
- `inta_i` rise sampled at t → ACK at t+1. At t+1, `vector_valid` = 1, `vector_o` is valid and `intr_o` = 0.
- `intr_o` may reassert from t+2.
- `inta_i` held high produces exactly one acknowledge. It must drop and rise again for the next one.
- `reset` asserted in ACK: the strobe is suppressed from the next cycle, and all state returns to reset values.
- `cfg_rdata` latency: 1 cycle.

## Structure
- Shared package `irq_pkg`:
  - FSM state enum (IDLE, ACK);
  - `cfg_addr` constants (IMR, MODE, EOI, STAT);
  - spurious-vector constant.
- One sub-module, `irq_prio_enc`: parametrised lowest-index priority encoder with outputs `idx` and `found`. It is instantiated twice, for `hp` and `hs`.

## Test plan
1. Reset, then write IMR = 0 and MODE = 8'hFF. Pulse `ir`[3] → `intr_o` at +2. Raise `inta_i` → `vector_o` = 8'h23, `vector_valid` for 1 cycle, ISR = 8'h08, IRR = 0.
2. With ISR[3] set, pulse `ir`[5] → `intr_o` stays 0. Pulse `ir`[1] → `intr_o` = 1; acknowledge gives 8'h21 and ISR = 8'h0A. EOI 8'h02 then EOI 8'h08 → `intr_o` rises for line 5 (8'h25).
3. Level line 0 held high with MODE[0] = 0: acknowledge, then EOI → `intr_o` reasserts. Drop `ir`[0] → IRR[0] = 0 and no further request.
4. IMR = 8'hFF, pulse `ir`[2] → IRR = 8'h04, `intr_o` = 0. Write IMR = 0 → `intr_o` asserts and the acknowledge returns 8'h22.
5. `inta_i` raised with nothing pending → `vector_o` = 8'hFF, ISR unchanged. `inta_i` held 10 cycles → exactly one `vector_valid`.
6. `AUTO_EOI` = 1: two acknowledges of line 4 in a row → ISR stays 0 throughout. Reset asserted during ACK → all outputs 0 the next cycle.
